// File: rtl/pulse_event_fifo.sv
// First-word-fall-through FIFO of pulse event vectors with one-cycle drop flag.
// Optional 8-bit saturating drop counter is enabled by PULSE_EVENT_FIFO_OVF_CNT_EN.
module pulse_event_fifo #(
   parameter int data_w = 1,
   parameter int depth  = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [data_w-1:0]            pulse_in,
   output logic                         ev_valid,
   output logic [data_w-1:0]            ev_data,
   input  logic                         ev_ready,
   output logic [$clog2(depth+1)-1:0]   count,
   output logic                         full,
   output logic                         overflow
`ifdef PULSE_EVENT_FIFO_OVF_CNT_EN
   ,
   output logic [7:0]                   ovf_cnt
`endif
);

   localparam int ptr_w = $clog2(depth);
   localparam int cnt_w = $clog2(depth + 1);
   localparam logic [cnt_w-1:0] depth_c = cnt_w'(depth);

   logic [data_w-1:0] mem [depth];
   logic [ptr_w-1:0]  wr_ptr;
   logic [ptr_w-1:0]  rd_ptr;
   logic              push;
   logic              pop;
   logic              wr_en;
   logic              drop;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push     = |pulse_in;
   assign pop      = ev_valid & ev_ready;
   assign wr_en    = push & (~full | pop);
   assign drop     = push & full & ~pop;
   assign ev_valid = (count != '0);
   assign full     = (count == depth_c);
   assign ev_data  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + ptr_w'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + ptr_w'(1);
         end
         case ({wr_en, pop})
            2'b10:   count <= count + cnt_w'(1);
            2'b01:   count <= count - cnt_w'(1);
            default: count <= count;
         endcase
         overflow <= drop;
      end
   end

   // Storage has no reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         mem[wr_ptr] <= pulse_in;
      end
   end

`ifdef PULSE_EVENT_FIFO_OVF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_cnt <= '0;
      end else if (drop && (ovf_cnt != 8'hFF)) begin
         ovf_cnt <= ovf_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pulse_event_fifo.sv
// Scoreboard bench for pulse_event_fifo (data_w=4, depth=4): a reference queue
// predicts every output each cycle; accepted pushes are queued, pops compared.
module tb_pulse_event_fifo;

   localparam int data_w = 4;
   localparam int depth  = 4;

   logic              clk;
   logic              rst;
   logic [data_w-1:0] pulse_in;
   logic              ev_valid;
   logic [data_w-1:0] ev_data;
   logic              ev_ready;
   logic [2:0]        count;
   logic              full;
   logic              overflow;
`ifdef PULSE_EVENT_FIFO_OVF_CNT_EN
   logic [7:0]        ovf_cnt;
`endif

   pulse_event_fifo #(.data_w(data_w), .depth(depth)) dut (
      .clk      (clk),
      .rst      (rst),
      .pulse_in (pulse_in),
      .ev_valid (ev_valid),
      .ev_data  (ev_data),
      .ev_ready (ev_ready),
      .count    (count),
      .full     (full),
      .overflow (overflow)
`ifdef PULSE_EVENT_FIFO_OVF_CNT_EN
      ,
      .ovf_cnt  (ovf_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [data_w-1:0] sb [$];
   logic model_ovf = 1'b0;
   int   model_ovf_cnt = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Called just after a falling edge: checks the current outputs against the
   // model, drives the inputs for the coming rising edge and advances the model.
   task automatic applyStimulus(input logic [data_w-1:0] p, input logic r);
      int  sz;
      logic do_pop;
      logic push;
      sz = sb.size();
      checkOutput("ev_valid", 32'(ev_valid), 32'(sz != 0));
      checkOutput("count", 32'(count), 32'(sz));
      checkOutput("full", 32'(full), 32'(sz == depth));
      checkOutput("overflow", 32'(overflow), 32'(model_ovf));
`ifdef PULSE_EVENT_FIFO_OVF_CNT_EN
      checkOutput("ovf_cnt", 32'(ovf_cnt), 32'(model_ovf_cnt));
`endif
      if (sz != 0) begin
         checkOutput("ev_data", 32'(ev_data), 32'(sb[0]));
      end
      pulse_in = p;
      ev_ready = r;
      do_pop = (sz != 0) && r;
      push   = (p != '0);
      if (do_pop) void'(sb.pop_front());
      if (push && ((sz < depth) || do_pop)) sb.push_back(p);
      model_ovf = push && (sz == depth) && !do_pop;
      if (model_ovf && model_ovf_cnt < 255) model_ovf_cnt++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic resetDut(input logic [data_w-1:0] p);
      rst = 1'b1;
      pulse_in = p;
      ev_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      pulse_in = '0;
      sb.delete();
      model_ovf = 1'b0;
      model_ovf_cnt = 0;
   endtask

   task automatic drain();
      for (int i = 0; i < depth + 2; i++) applyStimulus('0, 1'b1);
   endtask

   initial begin
      rst = 1'b1;
      pulse_in = '0;
      ev_ready = 1'b0;
      @(negedge clk);
      resetDut('0);

      // Single push, visible next cycle, then popped
      applyStimulus(4'b0101, 1'b0);
      applyStimulus(4'b0000, 1'b0);
      applyStimulus(4'b0000, 1'b1);
      applyStimulus(4'b0000, 1'b1);

      // Fill to full then drain in order
      applyStimulus(4'd1, 1'b0);
      applyStimulus(4'd2, 1'b0);
      applyStimulus(4'd4, 1'b0);
      applyStimulus(4'd8, 1'b0);
      applyStimulus(4'd0, 1'b0);
      drain();

      // Drop when full with no pop
      for (int i = 1; i <= 4; i++) applyStimulus(4'(i), 1'b0);
      applyStimulus(4'b0011, 1'b0);
      applyStimulus(4'b0000, 1'b0);
      applyStimulus(4'b0000, 1'b0);
      drain();

      // Push and pop together while full
      for (int i = 1; i <= 4; i++) applyStimulus(4'(i + 4), 1'b0);
      applyStimulus(4'b1111, 1'b1);
      applyStimulus(4'b0000, 1'b0);
      drain();

      // Push/pop pairs across the pointer wrap
      applyStimulus(4'd9, 1'b0);
      for (int i = 0; i < 10; i++) applyStimulus(4'((i % 15) + 1), 1'b1);
      drain();

      // Random traffic including more drops
      for (int i = 0; i < 60; i++)
         applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0));
      drain();

      // Reset mid-operation with a concurrent pulse
      for (int i = 1; i <= 3; i++) applyStimulus(4'(i * 3), 1'b0);
      resetDut(4'b0001);
      applyStimulus(4'b0000, 1'b1);
      applyStimulus(4'b0000, 1'b1);
      applyStimulus(4'b0000, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
